// File: rtl/fig_04b_block_068_cache_fetch_p.sv
// rtl/fig_04b_block_068_cache_fetch_p.sv - parametrised instruction cache and ROM fetch controller
// Caches a CBR-relative window of code and fills whole lines from ROM on a miss.
module fig_04b_block_068_cache_fetch_p #(
  parameter int ADDR_W     = 24,
  parameter int LINE_BYTES = 16,
  parameter int NUM_LINES  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_req,
  input  logic              cache_en,
  input  logic              cbr_load,
  input  logic [ADDR_W-1:0] cbr_in,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              rom_rdy,
  output logic [7:0]        instr_out,
  output logic              instr_valid,
  output logic              busy
);

  localparam int OFF_W       = $clog2(LINE_BYTES);
  localparam int LINE_W      = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int CACHE_BYTES = NUM_LINES * LINE_BYTES;
  localparam int WIN_W       = $clog2(CACHE_BYTES);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(LINE_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DELIVER, S_BYPASS} state_t;
  state_t state_q, state_d;

  logic [ADDR_W-1:0]    cbr_q;
  logic [ADDR_W-1:0]    off;
  logic [NUM_LINES-1:0] valid_q;
  logic [7:0]           ram [CACHE_BYTES];
  logic [LINE_W-1:0]    line_q, req_line;
  logic [OFF_W-1:0]     byte_q, cnt_q, req_byte;
  logic                 in_win, rom_xfer, fill_last;
  logic                 do_hit, do_fill, do_bypass, fill_step, byp_done, abort;

  // The window is CBR-relative and wraps modulo the address space.
  assign off       = pc - cbr_q;
  assign in_win    = (off[ADDR_W-1:WIN_W] == '0);
  assign req_line  = off[OFF_W +: LINE_W];
  assign req_byte  = off[OFF_W-1:0];
  assign rom_xfer  = rom_req & rom_rdy;
  assign fill_last = (cnt_q == OFF_W'(LINE_BYTES - 1));
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    do_hit    = 1'b0;
    do_fill   = 1'b0;
    do_bypass = 1'b0;
    fill_step = 1'b0;
    byp_done  = 1'b0;
    abort     = cbr_load & ((state_q == S_FILL) | (state_q == S_BYPASS));
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fetch_req && !cbr_load) begin
            if (cache_en && in_win) begin
              if (valid_q[req_line]) begin
                do_hit = 1'b1;
              end else begin
                do_fill = 1'b1;
                state_d = S_FILL;
              end
            end else begin
              do_bypass = 1'b1;
              state_d   = S_BYPASS;
            end
          end
        end
        S_FILL: begin
          fill_step = rom_xfer;
          if (rom_xfer && fill_last) state_d = S_DELIVER;
        end
        S_DELIVER: state_d = S_IDLE;
        S_BYPASS: begin
          byp_done = rom_xfer;
          if (rom_xfer) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cbr_q       <= '0;
      valid_q     <= '0;
      rom_req     <= 1'b0;
      rom_addr    <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      cnt_q       <= '0;
      line_q      <= '0;
      byte_q      <= '0;
    end else begin
      state_q     <= state_d;
      instr_valid <= 1'b0;
      if (do_hit) begin
        instr_out   <= ram[{req_line, req_byte}];
        instr_valid <= 1'b1;
      end
      // CBR is line aligned, so the line base is simply pc with the byte bits cleared.
      if (do_fill) begin
        rom_req  <= 1'b1;
        rom_addr <= pc & ~LOW_MASK;
        cnt_q    <= '0;
        line_q   <= req_line;
        byte_q   <= req_byte;
      end
      if (do_bypass) begin
        rom_req  <= 1'b1;
        rom_addr <= pc;
      end
      if (fill_step) begin
        cnt_q    <= cnt_q + OFF_W'(1);
        rom_addr <= rom_addr + ADDR_W'(1);
        if (fill_last) begin
          rom_req         <= 1'b0;
          valid_q[line_q] <= 1'b1;
        end
      end
      if (state_q == S_DELIVER) begin
        instr_out   <= ram[{line_q, byte_q}];
        instr_valid <= 1'b1;
      end
      if (byp_done) begin
        instr_out   <= rom_data;
        instr_valid <= 1'b1;
        rom_req     <= 1'b0;
      end
      if (abort) rom_req <= 1'b0;
      if (cbr_load) begin
        cbr_q   <= cbr_in & ~LOW_MASK;
        valid_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_step) ram[{line_q, cnt_q}] <= rom_data;
  end

endmodule

// File: tb/tb_fig_04b_block_068_cache_fetch_p.sv
// tb/tb_fig_04b_block_068_cache_fetch_p.sv - self-checking bench for the cache fetch controller
// Directed vector table, abort/reset corner sequences and a random run against a window/line model.
module tb_fig_04b_block_068_cache_fetch_p;

  localparam int AW = 24;
  localparam int LB = 16;
  localparam int NL = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc;
  logic          fetch_req, cache_en, cbr_load;
  logic [AW-1:0] cbr_in;
  logic          rom_req;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          rom_rdy;
  logic [7:0]    instr_out;
  logic          instr_valid, busy;

  fig_04b_block_068_cache_fetch_p #(.ADDR_W(AW), .LINE_BYTES(LB), .NUM_LINES(NL)) dut (
    .clk(clk), .reset(reset), .pc(pc), .fetch_req(fetch_req), .cache_en(cache_en),
    .cbr_load(cbr_load), .cbr_in(cbr_in), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_rdy(rom_rdy), .instr_out(instr_out),
    .instr_valid(instr_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'hA5;
  endfunction

  assign rom_data = rom_fn(rom_addr);

  int checks = 0;
  int failures = 0;
  logic [AW-1:0] rom_log[$];
  int req_cycles;
  int stall_err;
  bit stall_pend = 0;
  logic [AW-1:0] stall_addr;

  // ROM side monitor: accepted addresses, request cycles, address stability while stalled.
  always @(posedge clk) begin
    if (rom_req) req_cycles++;
    if (rom_req && rom_rdy) rom_log.push_back(rom_addr);
    if (stall_pend && rom_req && rom_addr !== stall_addr) stall_err++;
    stall_pend = rom_req && !rom_rdy;
    stall_addr = rom_addr;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  logic [AW-1:0] m_cbr;
  bit            m_valid[NL];

  task automatic model_clear(input logic [AW-1:0] c);
    m_cbr = c & ~AW'(LB - 1);
    for (int i = 0; i < NL; i++) m_valid[i] = 0;
  endtask

  task automatic load_cbr(input logic [AW-1:0] v);
    @(negedge clk);
    cbr_load = 1; cbr_in = v;
    @(negedge clk);
    cbr_load = 0;
    model_clear(v);
  endtask

  // Issues one fetch, checks it against the model, returns measured latency and ROM reads.
  task automatic check_fetch(input string nm, input logic [AW-1:0] p, input bit en, input bit rnd,
                             output int lat, output int nreads, output logic [AW-1:0] addr0);
    logic [AW-1:0] off, base;
    int line, kind, bad;
    logic [7:0] out;
    off  = p - m_cbr;
    line = int'(off) / LB;
    base = p - AW'(int'(off) % LB);
    if (en && off < AW'(NL * LB)) kind = m_valid[line] ? 0 : 1;
    else kind = 2;
    @(negedge clk);
    pc = p; cache_en = en; fetch_req = 1;
    rom_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    rom_log.delete(); req_cycles = 0; stall_err = 0;
    lat = -1; out = 'x;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      fetch_req = 0;
      pc = AW'($urandom);
      cache_en = 1'($urandom);
      rom_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (instr_valid) begin lat = k; out = instr_out; break; end
    end
    chk({nm, ".done"}, 32'(lat > 0), 1);
    nreads = rom_log.size();
    addr0 = (nreads > 0) ? rom_log[0] : '0;
    chk({nm, ".data"}, 32'(out), 32'(rom_fn(p)));
    chk({nm, ".stall"}, 32'(stall_err), 0);
    case (kind)
      0: begin
        chk({nm, ".hit_reads"}, 32'(nreads), 0);
        chk({nm, ".hit_lat"}, 32'(lat), 1);
      end
      1: begin
        bad = 0;
        for (int i = 0; i < nreads; i++) if (rom_log[i] !== base + AW'(i)) bad++;
        chk({nm, ".fill_reads"}, 32'(nreads), LB);
        chk({nm, ".fill_addrs"}, 32'(bad), 0);
        chk({nm, ".fill_lat"}, 32'(lat), 32'(req_cycles + 2));
        m_valid[line] = 1;
      end
      default: begin
        chk({nm, ".byp_reads"}, 32'(nreads), 1);
        chk({nm, ".byp_addr"}, 32'(addr0), 32'(p));
        chk({nm, ".byp_lat"}, 32'(lat), 32'(req_cycles + 1));
      end
    endcase
    @(negedge clk);
    chk({nm, ".strobe"}, 32'(instr_valid), 0);
    chk({nm, ".hold"}, 32'(instr_out), 32'(out));
    chk({nm, ".idle"}, 32'(busy), 0);
  endtask

  typedef struct {
    bit            load;
    logic [AW-1:0] cbr;
    logic [AW-1:0] pc;
    bit            en;
    int            exp_reads;
    logic [AW-1:0] exp_addr0;
    int            exp_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic wait_reads(input int n, input string nm);
    int k;
    for (k = 0; k < 100 && rom_log.size() < n; k++) @(negedge clk);
    chk(nm, 32'(rom_log.size()), 32'(n));
  endtask

  initial begin
    int lat, nr, vcnt;
    logic [AW-1:0] a0;
    vecs[0]  = '{0, 24'h000000, 24'h000005, 1, 16, 24'h000000, 18};
    vecs[1]  = '{0, 24'h000000, 24'h00000A, 1,  0, 24'h000000,  1};
    vecs[2]  = '{0, 24'h000000, 24'h000005, 0,  1, 24'h000005,  2};
    vecs[3]  = '{0, 24'h000000, 24'h000005, 1,  0, 24'h000000,  1};
    vecs[4]  = '{1, 24'hFFFF00, 24'h000010, 1, 16, 24'h000010, 18};
    vecs[5]  = '{0, 24'h000000, 24'hFFFEFF, 1,  1, 24'hFFFEFF,  2};
    vecs[6]  = '{0, 24'h000000, 24'hFFFF1F, 1, 16, 24'hFFFF10, 18};
    vecs[7]  = '{0, 24'h000000, 24'h0000FF, 1, 16, 24'h0000F0, 18};
    vecs[8]  = '{0, 24'h000000, 24'h000100, 1,  1, 24'h000100,  2};
    vecs[9]  = '{0, 24'h000000, 24'h000013, 1,  0, 24'h000000,  1};
    vecs[10] = '{1, 24'h000123, 24'h00012F, 1, 16, 24'h000120, 18};
    vecs[11] = '{0, 24'h000000, 24'h00011F, 1,  1, 24'h00011F,  2};

    reset = 0; pc = 0; fetch_req = 0; cache_en = 1; cbr_load = 0; cbr_in = 0; rom_rdy = 1;
    model_clear('0);
    repeat (3) @(negedge clk);
    chk("rst.rom_req", 32'(rom_req), 0);
    chk("rst.rom_addr", 32'(rom_addr), 0);
    chk("rst.instr_out", 32'(instr_out), 0);
    chk("rst.instr_valid", 32'(instr_valid), 0);
    chk("rst.busy", 32'(busy), 0);
    reset = 1;

    foreach (vecs[i]) begin
      if (vecs[i].load) load_cbr(vecs[i].cbr);
      check_fetch($sformatf("vec%0d", i), vecs[i].pc, vecs[i].en, 0, lat, nr, a0);
      chk($sformatf("vec%0d.reads", i), 32'(nr), 32'(vecs[i].exp_reads));
      chk($sformatf("vec%0d.lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (vecs[i].exp_reads > 0) chk($sformatf("vec%0d.addr0", i), 32'(a0), 32'(vecs[i].exp_addr0));
    end

    // cbr_load at cnt=7 aborts the fill without a strobe and invalidates everything.
    load_cbr(24'h000000);
    check_fetch("pre_abort", 24'h000005, 1, 0, lat, nr, a0);
    @(negedge clk);
    pc = 24'h000045; cache_en = 1; fetch_req = 1; rom_rdy = 1; rom_log.delete();
    @(negedge clk);
    fetch_req = 0;
    wait_reads(7, "abort.cnt7");
    cbr_load = 1; cbr_in = 24'h000000;
    @(negedge clk);
    cbr_load = 0;
    model_clear('0);
    chk("abort.rom_req", 32'(rom_req), 0);
    chk("abort.busy", 32'(busy), 0);
    chk("abort.valid", 32'(instr_valid), 0);
    vcnt = 0;
    repeat (4) begin @(negedge clk); vcnt += int'(instr_valid); end
    chk("abort.no_strobe", 32'(vcnt), 0);
    check_fetch("post_abort0", 24'h000005, 1, 0, lat, nr, a0);
    check_fetch("post_abort1", 24'h000045, 1, 0, lat, nr, a0);

    // Asynchronous reset mid-fill leaves the partial line invalid.
    @(negedge clk);
    pc = 24'h000030; cache_en = 1; fetch_req = 1; rom_rdy = 1; rom_log.delete();
    @(negedge clk);
    fetch_req = 0;
    wait_reads(5, "rstfill.cnt5");
    #2 reset = 0;
    #1;
    chk("rstfill.rom_req", 32'(rom_req), 0);
    chk("rstfill.busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1;
    model_clear('0);
    check_fetch("post_rst", 24'h000030, 1, 0, lat, nr, a0);

    // Random traffic with a 50% ROM ready duty cycle.
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] p;
      if (i % 8 == 3) begin
        if ($urandom_range(0, 1) == 1) load_cbr(24'hFFFF00 + AW'($urandom_range(0, 255)));
        else load_cbr(AW'($urandom));
      end
      if ($urandom_range(0, 3) != 0) p = m_cbr + AW'($urandom_range(0, 12'h27F));
      else p = AW'($urandom);
      check_fetch($sformatf("rnd%0d", i), p, $urandom_range(0, 4) != 0, 1, lat, nr, a0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
